// File: rtl/stb_mem_responder_pkg.sv
// Shared definitions for the store-buffer memory write responder.
// Contents:
//   DEFAULT_DATA_BITS / DEFAULT_ADDRESS_BITS : default bus widths
//   DONE_BITS                                : width of the completed-write counter
//   state_t                                  : responder FSM state encoding
package stb_mem_responder_pkg;

  localparam int DEFAULT_DATA_BITS    = 32;
  localparam int DEFAULT_ADDRESS_BITS = 32;
  localparam int DONE_BITS            = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/stb_mem_responder_if.sv
// Store-buffer / memory-array handshake bundle for stb_mem_responder.
// Signals:
//   wMemReq, wAddrMem, wDataMem : write request from the store-buffer head
//   wMemAck                     : write-complete pulse to the store buffer
//   memBusy                     : memory array owned by another requester
//   memWrite, memAddr, memData  : write port into the memory array
// Modports:
//   master : the environment (store buffer + memory array)
//   slave  : the responder
interface stb_mem_responder_if #(
  parameter int DATA_BITS    = 32,
  parameter int ADDRESS_BITS = 32
);

  logic                    wMemReq;
  logic [ADDRESS_BITS-1:0] wAddrMem;
  logic [DATA_BITS-1:0]    wDataMem;
  logic                    wMemAck;
  logic                    memBusy;
  logic                    memWrite;
  logic [ADDRESS_BITS-1:0] memAddr;
  logic [DATA_BITS-1:0]    memData;

  modport master (
    output wMemReq, wAddrMem, wDataMem, memBusy,
    input  wMemAck, memWrite, memAddr, memData
  );

  modport slave (
    input  wMemReq, wAddrMem, wDataMem, memBusy,
    output wMemAck, memWrite, memAddr, memData
  );

endinterface

// File: rtl/mem_lat_counter.sv
// Latency down-counter for the memory write strobe.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val (has priority over dec)
//   dec       : decrement by one, holding at zero
//   load_val  : value to load
//   zero      : count is zero
module mem_lat_counter #(
  parameter int CNT_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                dec,
  input  logic [CNT_BITS-1:0] load_val,
  output logic                zero
);

  logic [CNT_BITS-1:0] count_reg;

  // Holding at zero keeps a stray decrement from wrapping to all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign zero = (count_reg == '0);

endmodule

// File: rtl/stb_mem_responder.sv
// Store-buffer memory write responder. Accepts one write from the store-buffer
// head when the memory array is free, holds memWrite for MEM_LATENCY cycles,
// then pulses wMemAck for one cycle and counts the completed write.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   clear      : blocks acceptance of a new request while high
//   bus        : store-buffer / memory handshake (slave side)
//   writesDone : completed-write count, wraps modulo 2^16
// Parameters:
//   MEM_LATENCY (1..15) : cycles memWrite is held per write
//   CNT_BITS            : latency counter width
//   DONE_PRESET         : reset value of writesDone (0 in normal use; a nonzero
//                         value lets the wrap be exercised without 64k writes)
module stb_mem_responder
  import stb_mem_responder_pkg::*;
#(
  parameter int                   DATA_BITS    = DEFAULT_DATA_BITS,
  parameter int                   ADDRESS_BITS = DEFAULT_ADDRESS_BITS,
  parameter int                   MEM_LATENCY  = 5,
  parameter int                   CNT_BITS     = 4,
  parameter logic [DONE_BITS-1:0] DONE_PRESET  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  stb_mem_responder_if.slave   bus,
  output logic [DONE_BITS-1:0] writesDone
);

  localparam logic [CNT_BITS-1:0] LAT_LOAD = CNT_BITS'(MEM_LATENCY - 1);

  state_t                  state_reg, state_next;
  logic                    accept;
  logic                    cnt_zero;
  logic                    write_out, ack_out;
  logic [ADDRESS_BITS-1:0] addr_reg;
  logic [DATA_BITS-1:0]    data_reg;
  logic [DONE_BITS-1:0]    done_reg;

  // Acceptance only from IDLE, so ACK always separates two writes and the
  // store-buffer head gets a cycle to advance.
  assign accept = (state_reg == IDLE) && bus.wMemReq && !bus.memBusy && !clear;

  mem_lat_counter #(
    .CNT_BITS(CNT_BITS)
  ) u_lat (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .dec      (state_reg == WRITE),
    .load_val (LAT_LOAD),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; WRITE and ACK ignore all inputs (non-preemptive).
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = WRITE;
      WRITE:   if (cnt_zero) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    write_out = 1'b0;
    ack_out   = 1'b0;
    case (state_reg)
      WRITE:   write_out = 1'b1;
      ACK:     ack_out   = 1'b1;
      default: ;
    endcase
  end

  // Captured address/data stay on the memory bus until the next acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg <= '0;
      data_reg <= '0;
    end else if (accept) begin
      addr_reg <= bus.wAddrMem;
      data_reg <= bus.wDataMem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_reg <= DONE_PRESET;
    end else if (state_reg == ACK) begin
      done_reg <= done_reg + 1'b1;
    end
  end

  assign bus.memWrite = write_out;
  assign bus.wMemAck  = ack_out;
  assign bus.memAddr  = addr_reg;
  assign bus.memData  = data_reg;
  assign writesDone   = done_reg;

endmodule

// File: tb/tb_stb_mem_responder.sv
// Self-checking bench for stb_mem_responder: a MEM_LATENCY=5 instance driven
// from a vector table plus hand-written sequences, and a MEM_LATENCY=1 instance
// with a preset completion count for the edge cases.
module tb_stb_mem_responder;
  import stb_mem_responder_pkg::*;

  localparam int L = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear5 = 1'b0;
  logic        clear1 = 1'b0;
  logic [15:0] done5, done1;
  int          cyc = 0;
  int          compared = 0;
  int          mismatched = 0;
  int          exp_done5 = 0;
  int          wr_count = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stb_mem_responder_if #(.DATA_BITS(32), .ADDRESS_BITS(32)) bus5 ();
  stb_mem_responder_if #(.DATA_BITS(32), .ADDRESS_BITS(32)) bus1 ();

  stb_mem_responder #(
    .DATA_BITS(32), .ADDRESS_BITS(32), .MEM_LATENCY(5), .CNT_BITS(4), .DONE_PRESET(16'h0000)
  ) dut5 (
    .clk(clk), .rst(rst), .clear(clear5), .bus(bus5), .writesDone(done5)
  );

  stb_mem_responder #(
    .DATA_BITS(32), .ADDRESS_BITS(32), .MEM_LATENCY(1), .CNT_BITS(4), .DONE_PRESET(16'hFFFE)
  ) dut1 (
    .clk(clk), .rst(rst), .clear(clear1), .bus(bus1), .writesDone(done1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard for dut5: one entry per accepted request.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          ack_cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus5.memWrite || bus5.wMemAck)
        chk("write_ack_overlap", 64'(bus5.memWrite & bus5.wMemAck), 64'd0);
      if (bus5.memWrite) begin
        wr_count++;
        chk("write_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          chk("mem_addr", 64'(bus5.memAddr), 64'(sb[0].addr));
          chk("mem_data", 64'(bus5.memData), 64'(sb[0].data));
          chk("write_window", 64'((cyc >= sb[0].ack_cyc - L) && (cyc <= sb[0].ack_cyc - 1)), 64'd1);
        end
      end
      if (bus5.wMemAck) begin
        chk("ack_pending", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(e.ack_cyc));
          chk("write_cycles", 64'(wr_count), 64'(L));
          $display("ack dut5 cycle=%0d addr=0x%08h data=0x%08h writes=%0d", cyc, e.addr, e.data, wr_count);
        end
        wr_count = 0;
      end
    end
  end

  // Table vectors: single request with optional pre-acceptance busy/clear
  // cycles and optional busy/clear raised while the write is in flight.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          busy_n;
    int          clear_n;
    bit          mid_busy;
    bit          mid_clear;
    int          ack_rel;
  } vec_t;
  vec_t vecs[5];

  task automatic idle5();
    bus5.wMemReq  = 1'b0;
    bus5.memBusy  = 1'b0;
    bus5.wAddrMem = 32'h0;
    bus5.wDataMem = 32'h0;
    clear5        = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge with dut5 idle.
  task automatic run_vec(input vec_t v);
    int t0;
    int acc;
    acc = (v.busy_n > v.clear_n) ? v.busy_n : v.clear_n;
    t0  = cyc;
    sb.push_back('{addr: v.addr, data: v.data, ack_cyc: t0 + v.ack_rel});
    exp_done5++;
    for (int k = 0; k <= v.ack_rel + 1; k++) begin
      if (k > 0) @(negedge clk);
      if (k <= acc) begin
        bus5.wMemReq  = 1'b1;
        bus5.wAddrMem = v.addr;
        bus5.wDataMem = v.data;
        bus5.memBusy  = (k < v.busy_n);
        clear5        = (k < v.clear_n);
      end else begin
        // Head has been captured: scramble it and disturb busy/clear.
        bus5.wMemReq  = 1'b0;
        bus5.wAddrMem = ~v.addr;
        bus5.wDataMem = ~v.data;
        bus5.memBusy  = v.mid_busy;
        clear5        = v.mid_clear;
      end
    end
    chk("done_count", 64'(done5), 64'(exp_done5[15:0]));
    chk("hold_addr", 64'(bus5.memAddr), 64'(v.addr));
    chk("hold_data", 64'(bus5.memData), 64'(v.data));
    chk("ack_after", 64'(bus5.wMemAck), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    idle5();
    @(negedge clk);
  endtask

  // wMemReq held high through three entries; head advances after each ack.
  task automatic run_b2b();
    int t0;
    int idx;
    logic [31:0] a[3];
    logic [31:0] d[3];
    a = '{32'h0000_0100, 32'h0000_0104, 32'h0000_0108};
    d = '{32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
    t0 = cyc;
    for (int i = 0; i < 3; i++)
      sb.push_back('{addr: a[i], data: d[i], ack_cyc: t0 + 6 + 7 * i});
    for (int k = 0; k <= 21; k++) begin
      if (k > 0) @(negedge clk);
      idx = (k < 6) ? 0 : ((k < 13) ? 1 : 2);
      bus5.wMemReq  = (k < 20);
      bus5.wAddrMem = a[idx];
      bus5.wDataMem = d[idx];
    end
    exp_done5 += 3;
    chk("b2b_done", 64'(done5), 64'(exp_done5[15:0]));
    chk("b2b_drained", 64'(sb.size()), 64'd0);
    sb.delete();
    idle5();
    @(negedge clk);
  endtask

  // Reset asserted in the third write cycle of a request.
  task automatic run_reset_midwrite();
    int t0;
    t0 = cyc;
    sb.push_back('{addr: 32'h0000_0ABC, data: 32'hCAFE_F00D, ack_cyc: t0 + 6});
    bus5.wMemReq  = 1'b1;
    bus5.wAddrMem = 32'h0000_0ABC;
    bus5.wDataMem = 32'hCAFE_F00D;
    @(negedge clk);
    idle5();
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_write", 64'(bus5.memWrite), 64'd1);
    #2 rst = 1'b1;
    sb.delete();
    wr_count  = 0;
    exp_done5 = 0;
    #1;
    chk("rst_write_drop", 64'(bus5.memWrite), 64'd0);
    chk("rst_no_ack", 64'(bus5.wMemAck), 64'd0);
    chk("rst_done", 64'(done5), 64'd0);
    chk("rst_addr", 64'(bus5.memAddr), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // Any late ack from the aborted write hits an empty scoreboard.
    for (int k = 0; k < 8; k++) @(negedge clk);
    chk("rst_done_after", 64'(done5), 64'd0);
  endtask

  // MEM_LATENCY=1 instance: write in cycle 1 only, ack in cycle 2 only.
  task automatic run_l1(input logic [31:0] addr, input logic [31:0] data, input logic [15:0] exp_done);
    bus1.wMemReq  = 1'b1;
    bus1.wAddrMem = addr;
    bus1.wDataMem = data;
    for (int k = 0; k <= 3; k++) begin
      if (k > 0) begin
        @(negedge clk);
        bus1.wMemReq  = 1'b0;
        bus1.wAddrMem = ~addr;
        bus1.wDataMem = ~data;
      end
      chk("l1_write", 64'(bus1.memWrite), 64'(k == 1));
      chk("l1_ack", 64'(bus1.wMemAck), 64'(k == 2));
      if (k >= 1) begin
        chk("l1_addr", 64'(bus1.memAddr), 64'(addr));
        chk("l1_data", 64'(bus1.memData), 64'(data));
      end
    end
    chk("l1_done", 64'(done1), 64'(exp_done));
    $display("ack dut1 addr=0x%08h data=0x%08h writesDone=0x%04h", addr, data, done1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0040, 32'hDEAD_BEEF, 0, 0, 1'b0, 1'b0, 6};
    vecs[1] = '{32'h0000_1000, 32'h1234_5678, 4, 0, 1'b1, 1'b0, 10};
    vecs[2] = '{32'hFFFF_FFFC, 32'hA5A5_A5A5, 0, 3, 1'b0, 1'b1, 9};
    vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 2, 5, 1'b1, 1'b1, 11};
    vecs[4] = '{32'h8000_0000, 32'h0000_0000, 0, 0, 1'b1, 1'b1, 6};

    idle5();
    bus1.wMemReq  = 1'b0;
    bus1.memBusy  = 1'b0;
    bus1.wAddrMem = 32'h0;
    bus1.wDataMem = 32'h0;

    #1 rst = 1'b1;
    #1;
    chk("reset_write", 64'(bus5.memWrite), 64'd0);
    chk("reset_ack", 64'(bus5.wMemAck), 64'd0);
    chk("reset_addr", 64'(bus5.memAddr), 64'd0);
    chk("reset_data", 64'(bus5.memData), 64'd0);
    chk("reset_done", 64'(done5), 64'd0);
    chk("reset_done_preset", 64'(done1), 64'hFFFE);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // First vector is driven in the same cycle reset is released.
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    run_b2b();
    run_l1(32'h0000_0010, 32'h1111_1111, 16'hFFFF);
    run_l1(32'h0000_0020, 32'h2222_2222, 16'h0000);
    run_reset_midwrite();
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stb_mem_responder.md
STB_MEM_RESPONDER -- requirements
Module: stb_mem_responder

Interface
REQ-001 The block SHALL have parameter DATA_BITS, default 32, the write-data width in bits.
REQ-002 The block SHALL have parameter ADDRESS_BITS, default 32, the write-address width in bits.
REQ-003 The block SHALL have parameter MEM_LATENCY, default 5 (legal 1..15), the number of cycles memWrite is held per write.
REQ-004 The block SHALL have parameter CNT_BITS, default 4, the latency counter width.
REQ-005 Port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-006 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port clear, input, 1 bit: synchronous; blocks acceptance of a new request while high.
REQ-008 Port wMemReq, input, 1 bit: store-buffer head valid / write request.
REQ-009 Port wAddrMem, input, ADDRESS_BITS: write address from the store buffer.
REQ-010 Port wDataMem, input, DATA_BITS: write data from the store buffer.
REQ-011 Port wMemAck, output, 1 bit: write-complete pulse back to the store buffer.
REQ-012 Port memBusy, input, 1 bit: the memory array is owned by another requester (fill/read).
REQ-013 Port memWrite, output, 1 bit: write strobe to the memory array.
REQ-014 Port memAddr, output, ADDRESS_BITS: memory write address.
REQ-015 Port memData, output, DATA_BITS: memory write data.
REQ-016 Port writesDone, output, 16 bits: count of completed writes.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, WRITE and ACK.
REQ-018 In IDLE with wMemReq=1, memBusy=0 and clear=0 in cycle t, the block SHALL capture wAddrMem and wDataMem, load the counter with MEM_LATENCY-1 and enter WRITE.
REQ-019 In IDLE with any of wMemReq=0, memBusy=1 or clear=1, the block SHALL remain in IDLE and capture nothing.
REQ-020 In WRITE, memWrite SHALL be 1 and memAddr/memData SHALL drive the captured values; the counter SHALL decrement each cycle, and on counter=0 the FSM SHALL enter ACK.
REQ-021 For a request accepted in cycle t, memWrite SHALL be high in exactly cycles t+1..t+MEM_LATENCY and wMemAck SHALL be high only in cycle t+MEM_LATENCY+1.
REQ-022 In ACK, wMemAck SHALL be 1 and memWrite 0, writesDone SHALL increment by 1, and the next state SHALL be IDLE unconditionally.
REQ-023 A request SHALL NOT be accepted in ACK, even if wMemReq=1, so that the store buffer head can advance; maximum throughput is one write per MEM_LATENCY+2 cycles.
REQ-024 wMemAck and memWrite SHALL be Moore outputs decoded from registered state only, with no combinational path from any input.
REQ-025 In IDLE and ACK, memAddr/memData SHALL hold their last captured values.
REQ-026 WRITE SHALL be non-preemptive: changes on memBusy, clear or wMemReq during WRITE or ACK SHALL be ignored, and the write SHALL complete and be acked.
REQ-027 wAddrMem/wDataMem changes after capture SHALL NOT affect memAddr/memData.
REQ-028 writesDone SHALL wrap modulo 2^16 (0xFFFF+1 -> 0x0000).
REQ-029 The counter SHALL be CNT_BITS wide, with MEM_LATENCY-1 computed at CNT_BITS width; MEM_LATENCY=1 SHALL give exactly one WRITE cycle.

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force IDLE and drive wMemAck=0, memWrite=0, memAddr=0, memData=0, writesDone=0 and counter=0.
REQ-031 Reset asserted during WRITE SHALL drop memWrite without completing the write and SHALL NOT generate wMemAck.
REQ-032 After rst deasserts, the first request SHALL be acceptable on the first rising edge.

Structure
REQ-033 State encodings (IDLE=2'd0, WRITE=2'd1, ACK=2'd2) and the default DATA_BITS/ADDRESS_BITS constants SHALL reside in the shared processor package.
REQ-034 The latency down-counter (load, decrement, zero flag) SHALL be one sub-module, mem_lat_counter.

Verification
REQ-035 Single write: MEM_LATENCY=5, wMemReq=1, addr 0x00000040, data 0xDEADBEEF at t=0 -> memWrite high t=1..5 with memAddr 0x40 and memData 0xDEADBEEF, wMemAck high only at t=6, writesDone=1.
REQ-036 Back-to-back: wMemReq held high through 3 requests -> acks at t=6, 13 and 20, writesDone=3, and no acceptance in any ACK cycle.
REQ-037 Contention: memBusy=1 for t=0..3 with wMemReq=1 -> no memWrite until t=5, wMemAck at t=10; memBusy raised during WRITE does not stall.
REQ-038 Reset mid-write: rst pulsed at t=3 of a write -> memWrite=0 in the same cycle, no wMemAck, writesDone=0, and the next request is acked after MEM_LATENCY+1 cycles.
REQ-039 Edge cases: MEM_LATENCY=1 -> memWrite at t=1 only and ack at t=2; writesDone preset via 65535 writes plus one more reads 0x0000.
REQ-040 Clear: clear=1 with wMemReq=1 in IDLE -> stays IDLE; clear raised during WRITE -> write completes and is acked.
